ascon_ctrl_fsm: RTL and testbench

Sequencing controller for the ASCON-128 one-round-per-cycle permutation datapath. It drives the datapath's mux select, XOR enables, register enables and round index. It runs initialisation, one associated-data (AD) block, a stream of plaintext (PT) blocks and finalisation. It exposes a valid/ready data handshake and start/done control to the top level.

---
 rtl/ascon_ctrl_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_ascon_ctrl_fsm.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_ctrl_fsm.sv
// ascon_ctrl_fsm
// Sequencing controller for the one-round-per-cycle ASCON-128 permutation
// datapath: initialisation, one associated-data block, a stream of plaintext
// blocks, then finalisation.
//
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   i_start                   start pulse (IV||K||N valid on datapath i_state)
//   i_data_valid/i_data_last  data block handshake; last marks the final PT block
//   o_data_ready              block accepted when o_data_ready & i_data_valid
//   o_sys_enable              datapath enable; falls only in IDLE
//   o_mux_select              0 = load i_state, 1 = feedback
//   o_enable_xor_*            datapath XOR enables
//   o_enable_cipher_reg/tag_reg/state_reg   datapath register enables
//   o_round                   round index of the executing round (0 otherwise)
//   o_cipher_valid            pulse the cycle after the cipher register loads
//   o_busy, o_done            status
//
// Optional build macro ASCON_CTRL_CYCLE_CNT_EN adds o_cycle_count[15:0].
module ascon_ctrl_fsm #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_start,
  input  logic        i_data_valid,
  input  logic        i_data_last,
  output logic        o_data_ready,
  output logic        o_sys_enable,
  output logic        o_mux_select,
  output logic        o_enable_xor_key_begin,
  output logic        o_enable_xor_data_begin,
  output logic        o_enable_xor_key_end,
  output logic        o_enable_xor_lsb_end,
  output logic        o_enable_cipher_reg,
  output logic        o_enable_tag_reg,
  output logic        o_enable_state_reg,
  output logic [3:0]  o_round,
  output logic        o_cipher_valid,
  output logic        o_busy,
`ifdef ASCON_CTRL_CYCLE_CNT_EN
  output logic [15:0] o_cycle_count,
`endif
  output logic        o_done
);

  localparam logic [3:0] START_A    = 4'(12 - ROUNDS_A);
  localparam logic [3:0] START_B    = 4'(12 - ROUNDS_B);
  localparam logic [3:0] LAST_ROUND = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FINAL, S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_round;
  logic [3:0] w_round;
  logic       w_round_en;
  logic       w_mux_select;
  logic       w_xor_key_begin;
  logic       w_xor_data_begin;
  logic       w_xor_key_end;
  logic       w_xor_lsb_end;
  logic       w_cipher_reg;
  logic       w_tag_reg;
  logic       w_data_ready;
  logic       w_idle_or_done;
  logic       r_cipher_valid;

  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);

  // r_round holds the index of the next round of a running phase. The first
  // round of each phase executes in the start/handshake cycle, so its index
  // comes from the phase start constant instead of the register.
  always_comb begin
    w_next           = r_state;
    w_round          = '0;
    w_round_en       = 1'b0;
    w_mux_select     = 1'b0;
    w_xor_key_begin  = 1'b0;
    w_xor_data_begin = 1'b0;
    w_xor_key_end    = 1'b0;
    w_xor_lsb_end    = 1'b0;
    w_cipher_reg     = 1'b0;
    w_tag_reg        = 1'b0;
    w_data_ready     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_round_en = 1'b1;
          w_round    = START_A;
          w_next     = S_INIT;
        end
      end
      S_INIT: begin
        w_round_en   = 1'b1;
        w_mux_select = 1'b1;
        w_round      = r_round;
        if (r_round == LAST_ROUND) begin
          w_xor_key_end = 1'b1;
          w_next        = S_WAIT_AD;
        end
      end
      S_WAIT_AD: begin
        w_data_ready = 1'b1;
        if (i_data_valid) begin
          w_round_en       = 1'b1;
          w_mux_select     = 1'b1;
          w_round          = START_B;
          w_xor_data_begin = 1'b1;
          w_next           = S_AD;
        end
      end
      S_AD: begin
        w_round_en   = 1'b1;
        w_mux_select = 1'b1;
        w_round      = r_round;
        if (r_round == LAST_ROUND) begin
          w_xor_lsb_end = 1'b1;
          w_next        = S_WAIT_PT;
        end
      end
      S_WAIT_PT: begin
        w_data_ready = 1'b1;
        if (i_data_valid) begin
          w_round_en       = 1'b1;
          w_mux_select     = 1'b1;
          w_xor_data_begin = 1'b1;
          w_cipher_reg     = 1'b1;
          if (i_data_last) begin
            w_round         = START_A;
            w_xor_key_begin = 1'b1;
            w_next          = S_FINAL;
          end else begin
            w_round = START_B;
            w_next  = S_PT;
          end
        end
      end
      S_PT: begin
        w_round_en   = 1'b1;
        w_mux_select = 1'b1;
        w_round      = r_round;
        if (r_round == LAST_ROUND) begin
          w_next = S_WAIT_PT;
        end
      end
      S_FINAL: begin
        w_round_en   = 1'b1;
        w_mux_select = 1'b1;
        w_round      = r_round;
        if (r_round == LAST_ROUND) begin
          w_xor_key_end = 1'b1;
          w_tag_reg     = 1'b1;
          w_next        = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_round        <= '0;
      r_cipher_valid <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_cipher_valid <= w_cipher_reg;
      if (w_round_en) begin
        r_round <= (w_round == LAST_ROUND) ? '0 : w_round + 4'd1;
      end
    end
  end

`ifdef ASCON_CTRL_CYCLE_CNT_EN
  logic [15:0] r_cycle_count;

  // The accepted-start cycle already executes the first round, so the count
  // restarts at 1 rather than 0 to include it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle_count <= '0;
    end else if (i_start && w_idle_or_done) begin
      r_cycle_count <= 16'd1;
    end else if (!w_idle_or_done && (r_cycle_count != '1)) begin
      r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  assign o_cycle_count = r_cycle_count;
`endif

  assign o_data_ready            = w_data_ready;
  assign o_sys_enable            = (r_state != S_IDLE) || i_start;
  assign o_mux_select            = w_mux_select;
  assign o_enable_xor_key_begin  = w_xor_key_begin;
  assign o_enable_xor_data_begin = w_xor_data_begin;
  assign o_enable_xor_key_end    = w_xor_key_end;
  assign o_enable_xor_lsb_end    = w_xor_lsb_end;
  assign o_enable_cipher_reg     = w_cipher_reg;
  assign o_enable_tag_reg        = w_tag_reg;
  assign o_enable_state_reg      = w_round_en;
  assign o_round                 = w_round;
  assign o_cipher_valid          = r_cipher_valid;
  assign o_busy                  = !w_idle_or_done;
  assign o_done                  = (r_state == S_DONE);

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// tb_ascon_ctrl_fsm
// Scoreboard bench for ascon_ctrl_fsm: the driver issues cycle-scheduled
// start/data stimulus and pushes the expected round-cycle records, cipher-valid
// cycles and done cycles; a negedge monitor pops and compares.
module tb_ascon_ctrl_fsm;

  logic        clock;
  logic        reset_n;
  logic        i_start;
  logic        i_data_valid;
  logic        i_data_last;
  logic        o_data_ready;
  logic        o_sys_enable;
  logic        o_mux_select;
  logic        o_enable_xor_key_begin;
  logic        o_enable_xor_data_begin;
  logic        o_enable_xor_key_end;
  logic        o_enable_xor_lsb_end;
  logic        o_enable_cipher_reg;
  logic        o_enable_tag_reg;
  logic        o_enable_state_reg;
  logic [3:0]  o_round;
  logic        o_cipher_valid;
  logic        o_busy;
  logic        o_done;
`ifdef ASCON_CTRL_CYCLE_CNT_EN
  logic [15:0] o_cycle_count;
`endif

  ascon_ctrl_fsm #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .i_start                 (i_start),
    .i_data_valid            (i_data_valid),
    .i_data_last             (i_data_last),
    .o_data_ready            (o_data_ready),
    .o_sys_enable            (o_sys_enable),
    .o_mux_select            (o_mux_select),
    .o_enable_xor_key_begin  (o_enable_xor_key_begin),
    .o_enable_xor_data_begin (o_enable_xor_data_begin),
    .o_enable_xor_key_end    (o_enable_xor_key_end),
    .o_enable_xor_lsb_end    (o_enable_xor_lsb_end),
    .o_enable_cipher_reg     (o_enable_cipher_reg),
    .o_enable_tag_reg        (o_enable_tag_reg),
    .o_enable_state_reg      (o_enable_state_reg),
    .o_round                 (o_round),
    .o_cipher_valid          (o_cipher_valid),
    .o_busy                  (o_busy),
`ifdef ASCON_CTRL_CYCLE_CNT_EN
    .o_cycle_count           (o_cycle_count),
`endif
    .o_done                  (o_done)
  );

  // Record of one round cycle: {round[3:0], mux, key_begin, data_begin,
  // key_end, lsb_end, cipher_reg, tag_reg, busy, data_ready}
  typedef struct packed {
    int          cyc;
    logic [12:0] v;
  } rec_t;

  rec_t q_rnd[$];
  int   q_cv[$];
  int   q_done[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  bit   active  = 0;
  logic prev_done = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [12:0] mk(input int rnd, input bit mux, input bit kb,
                                     input bit db, input bit ke, input bit le,
                                     input bit creg, input bit treg,
                                     input bit busy, input bit rdy);
    return {4'(rnd), mux, kb, db, ke, le, creg, treg, busy, rdy};
  endfunction

  function automatic logic [16:0] all_outs();
    return {o_data_ready, o_sys_enable, o_mux_select, o_enable_xor_key_begin,
            o_enable_xor_data_begin, o_enable_xor_key_end, o_enable_xor_lsb_end,
            o_enable_cipher_reg, o_enable_tag_reg, o_enable_state_reg, o_round,
            o_cipher_valid, o_busy, o_done};
  endfunction

  task automatic push(input int c, input logic [12:0] v);
    rec_t r;
    r.cyc = c;
    r.v   = v;
    q_rnd.push_back(r);
  endtask

  // Start cycle (round 0, mux=0, not yet busy) then feedback rounds 1..11.
  task automatic push_init(input int t, input int n);
    for (int i = 0; i < n; i++)
      push(t + i, mk(i, i != 0, 0, 0, i == 11, 0, 0, 0, i != 0, 0));
  endtask

  task automatic push_ad(input int h);
    for (int i = 0; i < 6; i++)
      push(h + i, mk(6 + i, 1, 0, i == 0, 0, i == 5, 0, 0, 1, i == 0));
  endtask

  task automatic push_pt(input int h);
    for (int i = 0; i < 6; i++)
      push(h + i, mk(6 + i, 1, 0, i == 0, 0, 0, i == 0, 0, 1, i == 0));
    q_cv.push_back(h + 1);
  endtask

  task automatic push_last(input int h);
    for (int i = 0; i < 12; i++)
      push(h + i, mk(i, 1, i == 0, i == 0, i == 11, 0, i == 0, i == 11, 1, i == 0));
    q_cv.push_back(h + 1);
    q_done.push_back(h + 12);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // One full operation starting in the current cycle. Data valid is held high
  // except during the requested stall windows in WAIT_AD / WAIT_PT.
  task automatic run(input int ad_stall, input int npt, input int s0, input int s1,
                     input int s2, input bit extra_start, output int t_done);
    int t, h0, done;
    int hs[3];
    int ws[3];
    int st[3];
    bit stall;
    st[0] = s0; st[1] = s1; st[2] = s2;
    t     = cyc;
    h0    = t + 12 + ad_stall;
    ws[0] = h0 + 6;
    for (int k = 0; k < npt; k++) begin
      hs[k] = ws[k] + st[k];
      if (k < 2) ws[k + 1] = hs[k] + 6;
    end
    done = hs[npt - 1] + 12;
    for (int c = t; c < done; c++) begin
      stall = (c >= t + 12) && (c < h0);
      for (int k = 0; k < npt; k++)
        if (c >= ws[k] && c < hs[k]) stall = 1;
      i_start      = (c == t) || (extra_start && (c == h0 + 2 || c == hs[npt - 1] + 5));
      i_data_valid = !stall;
      i_data_last  = 1'b1;
      for (int k = 0; k < npt - 1; k++)
        if (c == hs[k]) i_data_last = 1'b0;
      if (c == t) begin
        active = 1;
        push_init(t, 12);
      end
      if (c == h0) push_ad(h0);
      for (int k = 0; k < npt; k++) begin
        if (c == hs[k]) begin
          if (k == npt - 1) push_last(hs[k]);
          else push_pt(hs[k]);
        end
      end
      tick();
    end
    i_start      = 1'b0;
    i_data_valid = 1'b0;
    i_data_last  = 1'b0;
    t_done       = done;
  endtask

  // Monitor
  always @(negedge clock) begin
    logic [12:0] act;
    if (reset_n) begin
      act = {o_round, o_mux_select, o_enable_xor_key_begin, o_enable_xor_data_begin,
             o_enable_xor_key_end, o_enable_xor_lsb_end, o_enable_cipher_reg,
             o_enable_tag_reg, o_busy, o_data_ready};
      check("sys_enable", 32'(o_sys_enable), 32'(active | i_start));
      while (q_rnd.size() > 0 && q_rnd[0].cyc < cyc) begin
        n_total++; n_bad++;
        $display("FAIL round_missing cyc=%0d got=none want=%0h@%0d", cyc, q_rnd[0].v, q_rnd[0].cyc);
        void'(q_rnd.pop_front());
      end
      if (o_enable_state_reg) begin
        if (q_rnd.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL round_unexpected cyc=%0d got=%0h want=none", cyc, act);
        end else begin
          rec_t r;
          r = q_rnd.pop_front();
          check("round_cycle", 32'(cyc), 32'(r.cyc));
          check("round_fields", 32'(act), 32'(r.v));
        end
      end else begin
        check("idle_enables", 32'(act[12:1] & 12'hFFC | act[12:1] & 12'h003 & 12'h000),
              32'h0);
      end
      while (q_cv.size() > 0 && q_cv[0] < cyc) begin
        n_total++; n_bad++;
        $display("FAIL cipher_valid_missing cyc=%0d got=none want=%0d", cyc, q_cv[0]);
        void'(q_cv.pop_front());
      end
      if (o_cipher_valid) begin
        if (q_cv.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL cipher_valid_unexpected cyc=%0d got=1 want=0", cyc);
        end else check("cipher_valid_cycle", 32'(cyc), 32'(q_cv.pop_front()));
      end
      while (q_done.size() > 0 && q_done[0] < cyc) begin
        n_total++; n_bad++;
        $display("FAIL done_missing cyc=%0d got=none want=%0d", cyc, q_done[0]);
        void'(q_done.pop_front());
      end
      if (o_done && !prev_done) begin
        if (q_done.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL done_unexpected cyc=%0d got=1 want=0", cyc);
        end else check("done_cycle", 32'(cyc), 32'(q_done.pop_front()));
      end
      prev_done = o_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int td;
    reset_n      = 1'b0;
    i_start      = 1'b0;
    i_data_valid = 1'b0;
    i_data_last  = 1'b0;
    #3;
    check("reset_outputs", 32'(all_outs()), 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("idle_outputs", 32'(all_outs()), 32'h0);

    // 1: nominal run, one AD block, one PT block
    run(0, 1, 0, 0, 0, 0, td);
`ifdef ASCON_CTRL_CYCLE_CNT_EN
    check("cycle_count", 32'(o_cycle_count), 32'd30);
`endif
    tick(); tick();

    // 2: 5-cycle stall in WAIT_AD, 3-cycle stall in WAIT_PT
    run(5, 1, 3, 0, 0, 0, td);
    tick(); tick();

    // 3: three PT blocks
    run(0, 3, 0, 2, 1, 0, td);
    tick(); tick();

    // 4: start pulses during AD and FINAL are ignored
    run(0, 1, 0, 0, 0, 1, td);
    tick(); tick();

    // 5: reset in INIT round 5, then a fresh nominal run
    begin
      int t;
      t = cyc;
      i_start = 1'b1;
      push_init(t, 6);
      tick();
      i_start = 1'b0;
      for (int c = t + 1; c < t + 5; c++) tick();
      #5;
      reset_n = 1'b0;
      active  = 0;
      #1;
      check("async_reset_outputs", 32'(all_outs()), 32'h0);
      tick();
      check("held_reset_outputs", 32'(all_outs()), 32'h0);
      reset_n = 1'b1;
      tick();
      check("post_reset_idle", 32'(all_outs()), 32'h0);
    end
    run(0, 1, 0, 0, 0, 0, td);

    // 6: back-to-back start while in DONE
    run(0, 1, 0, 0, 0, 0, td);
    tick(); tick(); tick();

    foreach (q_rnd[i]) begin
      n_total++; n_bad++;
      $display("FAIL round_leftover got=none want=%0h@%0d", q_rnd[i].v, q_rnd[i].cyc);
    end
    foreach (q_cv[i]) begin
      n_total++; n_bad++;
      $display("FAIL cipher_valid_leftover got=none want=%0d", q_cv[i]);
    end
    foreach (q_done[i]) begin
      n_total++; n_bad++;
      $display("FAIL done_leftover got=none want=%0d", q_done[i]);
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
